preddr_64to18_unpacker: RTL and testbench

Read-side unpacker for the DDR capture path. It takes 64-bit words read back from DDR, either from the pre-DDR FIFO or from the DDR read port. It re-slices them, MSB first, into a stream of 18-bit samples (normal mode) or 8-bit samples (4-bit LA mode). It stops after a programmed sample count and discards filler bits left in the last word. It sits between the DDR read FIFO and the USB/streaming readout logic.

---
 rtl/preddr_64to18_unpacker.sv | 122 ++++++++++++
 tb/tb_preddr_64to18_unpacker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/preddr_64to18_unpacker.sv
// Re-slices 64-bit DDR read words, MSB first, into 18-bit (or 8-bit LA-mode) samples.
// Optional starvation counter is enabled by defining PREDDR_UNPACK_STATS_EN.
module preddr_64to18_unpacker #(
  parameter int COUNT_W = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               I_4bit_mode,
  input  logic [COUNT_W-1:0] num_samples,
  input  logic [63:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [17:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [15:0]        underrun_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [99:0]        data_buf, buf_next;
  logic [6:0]         bits_avail, bits_next;
  logic [COUNT_W-1:0] remaining, remaining_next;
  logic               mode8;
  logic [6:0]         w;
  logic [6:0]         pos;
  logic               buffered;
  logic               fire_in, fire_out;

  assign w        = mode8 ? 7'd8 : 7'd18;
  assign out_data = mode8 ? {10'd0, data_buf[99:92]} : data_buf[99:82];
  assign fire_in  = in_ready && in_valid;
  assign fire_out = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    buffered   = (bits_avail >= w);
    case (state)
      IDLE: ;
      RUN: begin
        busy      = 1'b1;
        out_valid = (bits_avail >= w);
        // never fetch a word whose bits would only be thrown away at the end
        in_ready  = (bits_avail < (w << 1)) &&
                    (remaining > {{(COUNT_W-1){1'b0}}, buffered});
        if (out_valid && out_ready && remaining == COUNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (start) state_next = (num_samples != '0) ? RUN : DONE;
  end

  always_comb begin
    pos            = bits_avail - (fire_out ? w : 7'd0);
    buf_next       = fire_out ? (data_buf << w) : data_buf;
    bits_next      = pos + (fire_in ? 7'd64 : 7'd0);
    remaining_next = remaining - {{(COUNT_W-1){1'b0}}, fire_out};
    // bits below bits_avail are always zero, so the new word can simply be ORed in
    if (fire_in) buf_next = buf_next | ({in_data, 36'd0} >> pos);
    if (state == DONE) begin
      buf_next  = '0;
      bits_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_buf   <= '0;
      bits_avail <= '0;
      remaining  <= '0;
      mode8      <= 1'b0;
    end else if (start) begin
      data_buf   <= '0;
      bits_avail <= '0;
      remaining  <= num_samples;
      mode8      <= I_4bit_mode;
    end else begin
      data_buf   <= buf_next;
      bits_avail <= bits_next;
      remaining  <= remaining_next;
    end
  end

`ifdef PREDDR_UNPACK_STATS_EN
  logic [15:0] underrun_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_q <= '0;
    end else if (start) begin
      underrun_q <= '0;
    end else if (state == RUN && out_ready && !out_valid && underrun_q != 16'hFFFF) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_count = underrun_q;
`else
  assign underrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_preddr_64to18_unpacker.sv
// Directed bench for preddr_64to18_unpacker: reslice vectors, throughput, abort, reset and stats.
module tb_preddr_64to18_unpacker;
  localparam int COUNT_W = 24;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               I_4bit_mode = 1'b0;
  logic [COUNT_W-1:0] num_samples = '0;
  logic [63:0]        in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [17:0]        out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               busy;
  logic               done;
  logic [15:0]        underrun_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] words[$];
  logic [17:0] got[$];
  int          stamps[$];
  int          words_taken;
  bit          done_seen;
  int          done_cyc;
  int          stall_err;

  preddr_64to18_unpacker #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .I_4bit_mode(I_4bit_mode),
    .num_samples(num_samples), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // bit-serial reference: sample k is stream bits k*W .. k*W+W-1, stream bit 0 = words[0][63]
  function automatic logic [17:0] golden(input int k, input bit m8);
    int          wd;
    int          i;
    logic [17:0] r;
    wd = m8 ? 8 : 18;
    r  = '0;
    for (int b = 0; b < wd; b++) begin
      i = k * wd + b;
      r = {r[16:0], words[i / 64][63 - (i % 64)]};
    end
    return r;
  endfunction

  task automatic start_job(input bit m8, input int n);
    start       = 1'b1;
    I_4bit_mode = m8;
    num_samples = COUNT_W'(n);
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input int max_cycles, input bit rnd);
    int          widx;
    bit          prev_stall;
    logic [17:0] prev_data;
    logic        ir, ov;
    logic [17:0] od;
    bit          iv, orr;
    widx = 0; prev_stall = 0; prev_data = '0;
    got.delete(); stamps.delete();
    done_seen = 0; done_cyc = -1; stall_err = 0;
    for (int c = 0; c < max_cycles; c++) begin
      if (done) begin
        done_seen = 1;
        done_cyc  = c;
        break;
      end
      ir = in_ready; ov = out_valid; od = out_data;
      if (prev_stall && (!ov || od !== prev_data)) stall_err++;
      iv  = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      orr = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      in_valid  = iv && (widx < words.size());
      in_data   = (widx < words.size()) ? words[widx] : 64'd0;
      out_ready = orr;
      if (ir && in_valid) widx++;
      if (ov && orr) begin
        got.push_back(od);
        stamps.push_back(c);
      end
      prev_stall = ov && !orr;
      prev_data  = od;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    words_taken = widx;
  endtask

  initial begin
    int          mism;
    logic [17:0] orv;
    logic [17:0] exp8[8];

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", 32'(in_ready), 0);
    check_output("rst_out_valid", 32'(out_valid), 0);
    check_output("rst_out_data", 32'(out_data), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_done", 32'(done), 0);
    check_output("rst_underrun", 32'(underrun_count), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 8-bit mode, one word, eight byte samples
    exp8 = '{18'h00, 18'h11, 18'h22, 18'h33, 18'h44, 18'h55, 18'h66, 18'h77};
    words.delete();
    words.push_back(64'h0011223344556677);
    start_job(1'b1, 8);
    check_output("t1_busy_n1", 32'(busy), 1);
    check_output("t1_in_ready_n1", 32'(in_ready), 1);
    run_job(100, 1'b0);
    check_output("t1_done_seen", 32'(done_seen), 1);
    check_output("t1_count", 32'(got.size()), 8);
    if (got.size() == 8) begin
      for (int k = 0; k < 8; k++) check_output($sformatf("t1_sample%0d", k), 32'(got[k]), 32'(exp8[k]));
      check_output("t1_first_latency", 32'(stamps[0]), 1);
      check_output("t1_consecutive", 32'(stamps[7] - stamps[0]), 7);
      check_output("t1_done_cycle", 32'(done_cyc), 32'(stamps[7] + 1));
    end
    check_output("t1_words", 32'(words_taken), 1);
    @(posedge clk); #1;
    check_output("t1_idle_busy", 32'(busy), 0);
    check_output("t1_idle_done", 32'(done), 0);

    // 18-bit mode, 9 words carry exactly 32 samples
    words.delete();
    words.push_back(64'hFFFFC00000000000);
    for (int i = 1; i < 9; i++) words.push_back(64'd0);
    start_job(1'b0, 32);
    run_job(200, 1'b0);
    check_output("t2_done_seen", 32'(done_seen), 1);
    check_output("t2_count", 32'(got.size()), 32);
    if (got.size() == 32) begin
      check_output("t2_sample0", 32'(got[0]), 32'h3FFFF);
      orv = '0;
      for (int k = 1; k < 32; k++) orv = orv | got[k];
      check_output("t2_rest_zero", 32'(orv), 0);
      check_output("t2_no_bubbles", 32'(stamps[31] - stamps[0]), 31);
      check_output("t2_done_cycle", 32'(done_cyc), 32'(stamps[31] + 1));
    end
    check_output("t2_words", 32'(words_taken), 9);

    // 18-bit, 5 samples: only 2 words pulled, trailing 38 bits dropped
    words.delete();
    words.push_back(64'hFFFFFFFFFFFFFFFF);
    words.push_back(64'h0000000000000000);
    words.push_back(64'hFFFFFFFFFFFFFFFF);
    start_job(1'b0, 5);
    run_job(100, 1'b0);
    check_output("t3_done_seen", 32'(done_seen), 1);
    check_output("t3_count", 32'(got.size()), 5);
    if (got.size() == 5) begin
      check_output("t3_s0", 32'(got[0]), 32'h3FFFF);
      check_output("t3_s2", 32'(got[2]), 32'h3FFFF);
      check_output("t3_s3", 32'(got[3]), 32'h3FF00);
      check_output("t3_s4", 32'(got[4]), 32'h00000);
    end
    check_output("t3_words", 32'(words_taken), 2);

    // random handshakes over 288 counting-pattern words
    words.delete();
    for (int i = 0; i < 32 * 9; i++)
      words.push_back({16'(i), 16'(i + 1000), 16'(~i), 16'(i * 7)});
    start_job(1'b0, 32 * 32);
    run_job(20000, 1'b1);
    check_output("t4_done_seen", 32'(done_seen), 1);
    check_output("t4_count", 32'(got.size()), 1024);
    mism = 0;
    for (int k = 0; k < got.size(); k++) if (got[k] !== golden(k, 1'b0)) mism++;
    check_output("t4_data_mismatches", 32'(mism), 0);
    check_output("t4_stall_unstable", 32'(stall_err), 0);
    check_output("t4_words", 32'(words_taken), 288);

    // abort mid-RUN with num_samples = 0, then a normal job
    start_job(1'b0, 10);
    in_valid = 1'b1;
    in_data  = 64'h123456789ABCDEF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("t5_pre_out_valid", 32'(out_valid), 1);
    start       = 1'b1;
    num_samples = '0;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("t5_done", 32'(done), 1);
    check_output("t5_out_valid", 32'(out_valid), 0);
    check_output("t5_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("t5_idle_busy", 32'(busy), 0);
    check_output("t5_idle_done", 32'(done), 0);
    words.delete();
    words.push_back(64'hA5C3000000000000);
    start_job(1'b1, 2);
    run_job(50, 1'b0);
    check_output("t5_after_count", 32'(got.size()), 2);
    if (got.size() == 2) begin
      check_output("t5_after_s0", 32'(got[0]), 32'hA5);
      check_output("t5_after_s1", 32'(got[1]), 32'hC3);
    end
    check_output("t5_after_words", 32'(words_taken), 1);

    // asynchronous reset in the middle of a job
    start_job(1'b0, 4);
    in_valid = 1'b1;
    in_data  = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("t6_pre_out_valid", 32'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_out_valid", 32'(out_valid), 0);
    check_output("t6_rst_busy", 32'(busy), 0);
    check_output("t6_rst_out_data", 32'(out_data), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // starvation counter: 10 RUN cycles with out_ready high and nothing to send
    start_job(1'b0, 4);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b0;
`ifdef PREDDR_UNPACK_STATS_EN
    check_output("t7_underrun", 32'(underrun_count), 10);
`else
    check_output("t7_underrun", 32'(underrun_count), 0);
`endif
    start_job(1'b0, 0);
    check_output("t7_cleared", 32'(underrun_count), 0);
    check_output("t7_done", 32'(done), 1);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
